// File: rtl/bpi_seq_pkg.sv
// Shared types and helpers for the BPI flash scheduler/sequencer.
// The request struct is sized for the board's 26-bit word address, 16-bit flash part.
package bpi_seq_pkg;

    localparam int FLASH_ADDR_W = 26;
    localparam int FLASH_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE,
        S_TURN
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [FLASH_ADDR_W-1:0] addr;
        logic [FLASH_DATA_W-1:0] wdata;
    } req_t;

    // clog2 of the largest timing value plus one bit of headroom
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        w = 0;
        while ((1 << w) < m) w++;
        return w + 1;
    endfunction

endpackage

// File: rtl/bpi_rr_arb2.sv
// Two-port round-robin grant; the pointer remembers which port was served last.
module bpi_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // last_port = 1 means port 1 was served last, so port 0 wins a tie
    logic last_port;

    always_comb begin
        grant0 = valid0 && (!valid1 || last_port);
        grant1 = valid1 && !grant0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_port <= 1'b1;
        end else if (accept) begin
            last_port <= grant1;
        end
    end

endmodule

// File: rtl/bpi_flash_seq.sv
// Round-robin scheduler and async read/write timing sequencer for the 16-bit BPI flash.
// Every flash pin and response output comes straight from a register.
module bpi_flash_seq
    import bpi_seq_pkg::*;
#(
    parameter int ADDR_W   = FLASH_ADDR_W,
    parameter int DATA_W   = FLASH_DATA_W,
    parameter int RD_WAIT  = 8,
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 6,
    parameter int WR_HOLD  = 2,
    parameter int TURN     = 2
) (
    input  logic              CLK,
    input  logic              RESET,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [0:ADDR_W-1] flash_addr,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_adv_ldn,
    output logic [DATA_W-1:0] flash_data_o,
    output logic [DATA_W-1:0] flash_data_t,
    input  logic [DATA_W-1:0] flash_data_i,
    output logic              busy
);

    localparam int CNT_W = cnt_width(RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, TURN);

    localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'((TURN > 0) ? TURN - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cur_port;
    logic             grant0;
    logic             grant1;
    logic             accept;
    req_t             sel;

    bpi_rr_arb2 u_arb (
        .clk    (CLK),
        .reset  (RESET),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Ready is held low during reset so nothing is accepted while the FSM is being cleared
    always_comb begin
        req0_ready = (state == S_IDLE) && grant0 && !RESET;
        req1_ready = (state == S_IDLE) && grant1 && !RESET;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        sel.we    = req0_we;
        sel.addr  = req0_addr;
        sel.wdata = req0_wdata;
        if (grant1) begin
            sel.we    = req1_we;
            sel.addr  = req1_addr;
            sel.wdata = req1_wdata;
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            cnt           <= '0;
            cur_port      <= 1'b0;
            flash_addr    <= '0;
            flash_ce_n    <= 1'b1;
            flash_oe_n    <= 1'b1;
            flash_we_n    <= 1'b1;
            flash_adv_ldn <= 1'b1;
            flash_data_o  <= '0;
            flash_data_t  <= '1;
            rsp0_valid    <= 1'b0;
            rsp0_rdata    <= '0;
            rsp1_valid    <= 1'b0;
            rsp1_rdata    <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_port      <= grant1;
                        flash_addr    <= sel.addr;
                        flash_ce_n    <= 1'b0;
                        flash_adv_ldn <= 1'b0;
                        if (sel.we) begin
                            flash_data_o <= sel.wdata;
                            flash_data_t <= '0;
                            cnt          <= SETUP_LOAD;
                            state        <= S_WR_SETUP;
                        end else begin
                            flash_oe_n   <= 1'b0;
                            flash_data_t <= '1;
                            cnt          <= RD_LOAD;
                            state        <= S_RD_ACC;
                        end
                    end
                end
                S_RD_ACC: begin
                    if (cnt == '0) begin
                        flash_ce_n    <= 1'b1;
                        flash_oe_n    <= 1'b1;
                        flash_adv_ldn <= 1'b1;
                        if (cur_port) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= flash_data_i;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= flash_data_i;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    if (cnt == '0) begin
                        flash_we_n <= 1'b0;
                        cnt        <= PULSE_LOAD;
                        state      <= S_WR_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        flash_we_n <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    if (cnt == '0) begin
                        flash_ce_n    <= 1'b1;
                        flash_adv_ldn <= 1'b1;
                        flash_data_t  <= '1;
                        flash_data_o  <= '0;
                        if (cur_port) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= '0;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= '0;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    rsp0_rdata <= '0;
                    rsp1_rdata <= '0;
                    if (TURN > 0) begin
                        cnt   <= TURN_LOAD;
                        state <= S_TURN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TURN: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpi_flash_seq.sv
// Scoreboard bench for bpi_flash_seq: per-cycle strobe timeline, round-robin model and rsp queues.
module tb_bpi_flash_seq;

    localparam int AW  = 26;
    localparam int DW  = 16;
    localparam int RD  = 8;
    localparam int S   = 2;
    localparam int P   = 6;
    localparam int H   = 2;
    localparam int TRN = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    logic rst_q = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RESET;
    end

    // main instance signals
    logic          req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [0:AW-1] flash_addr;
    logic          flash_ce_n, flash_oe_n, flash_we_n, flash_adv_ldn, busy;
    logic [DW-1:0] flash_data_o, flash_data_t, flash_data_i;
    logic [AW-1:0] addr_num;

    // fast instance signals (RD_WAIT=1, TURN=0)
    logic          f_req0_valid = 0, f_req0_we = 0, f_req1_valid = 0, f_req1_we = 0;
    logic [AW-1:0] f_req0_addr = '0, f_req1_addr = '0;
    logic [DW-1:0] f_req0_wdata = '0, f_req1_wdata = '0;
    logic          f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [DW-1:0] f_rsp0_rdata, f_rsp1_rdata;
    logic [0:AW-1] f_flash_addr;
    logic          f_ce_n, f_oe_n, f_we_n, f_adv_ldn, f_busy;
    logic [DW-1:0] f_data_o, f_data_t, f_data_i;
    logic [AW-1:0] f_addr_num;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA479;
    endfunction

    // pin index 0 is the MSB, so a plain assignment recovers the numeric word address
    assign addr_num     = flash_addr;
    assign f_addr_num   = f_flash_addr;
    assign flash_data_i = (!flash_ce_n && !flash_oe_n) ? pat(addr_num) : 16'h0000;
    assign f_data_i     = (!f_ce_n && !f_oe_n) ? pat(f_addr_num) : 16'h0000;

    bpi_flash_seq dut (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .flash_addr(flash_addr), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n), .flash_adv_ldn(flash_adv_ldn),
        .flash_data_o(flash_data_o), .flash_data_t(flash_data_t),
        .flash_data_i(flash_data_i), .busy(busy)
    );

    bpi_flash_seq #(.RD_WAIT(1), .TURN(0)) dut_fast (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_we(f_req0_we),
        .req0_addr(f_req0_addr), .req0_wdata(f_req0_wdata),
        .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_we(f_req1_we),
        .req1_addr(f_req1_addr), .req1_wdata(f_req1_wdata),
        .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata),
        .flash_addr(f_flash_addr), .flash_ce_n(f_ce_n), .flash_oe_n(f_oe_n),
        .flash_we_n(f_we_n), .flash_adv_ldn(f_adv_ldn),
        .flash_data_o(f_data_o), .flash_data_t(f_data_t),
        .flash_data_i(f_data_i), .busy(f_busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    typedef struct {
        int port;
        int cyc;
    } acc_t;

    exp_t q0[$];
    exp_t q1[$];
    acc_t acc_log[$];

    logic          active = 1'b0;
    int            acc_cyc = 0;
    logic          acc_we = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic          last_port = 1'b1;

    task automatic strobes_idle(input string tag);
        check({tag, "_ce_n"}, 32'(flash_ce_n), 1);
        check({tag, "_oe_n"}, 32'(flash_oe_n), 1);
        check({tag, "_we_n"}, 32'(flash_we_n), 1);
        check({tag, "_adv"}, 32'(flash_adv_ldn), 1);
        check({tag, "_data_t"}, 32'(flash_data_t), 32'hFFFF);
    endtask

    task automatic rsp_chk(input int p, input logic v, input logic [DW-1:0] d);
        exp_t e;
        logic hit;
        hit = 1'b0;
        if (p == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
        end
        if (hit) begin
            check($sformatf("rsp%0d_valid", p), 32'(v), 1);
            check($sformatf("rsp%0d_rdata", p), 32'(d), 32'(e.rdata));
        end else begin
            check($sformatf("rsp%0d_spurious", p), 32'(v), 0);
        end
    endtask

    always @(negedge CLK) begin : mon
        int   k;
        int   done_k;
        logic er0;
        logic er1;
        exp_t e;

        check("inv_oe_t", 32'(!flash_oe_n && (flash_data_t != 16'hFFFF)), 0);
        check("inv_we", 32'(!flash_we_n && !(!flash_ce_n && flash_data_t == 16'h0000)), 0);
        check("rdy_both", 32'(req0_ready && req1_ready), 0);
        check("f_inv_oe_t", 32'(!f_oe_n && (f_data_t != 16'hFFFF)), 0);
        check("f_inv_we", 32'(!f_we_n && !(!f_ce_n && f_data_t == 16'h0000)), 0);
        check("f_rdy_both", 32'(f_req0_ready && f_req1_ready), 0);

        if (rst_q) begin
            strobes_idle("rst");
            check("rst_data_o", 32'(flash_data_o), 0);
            check("rst_addr", 32'(addr_num), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_rsp0_rdata", 32'(rsp0_rdata), 0);
            check("rst_rsp1_rdata", 32'(rsp1_rdata), 0);
            active    = 1'b0;
            last_port = 1'b1;
            q0.delete();
            q1.delete();
        end else begin
            done_k = acc_we ? (S + P + H + 1) : (RD + 1);
            k = cyc - acc_cyc;
            if (active && k > done_k + TRN) active = 1'b0;
            if (active) begin
                check("busy_act", 32'(busy), 1);
                if (k < done_k) begin
                    check("acc_ce_n", 32'(flash_ce_n), 0);
                    check("acc_adv", 32'(flash_adv_ldn), 0);
                    check("acc_addr", 32'(addr_num), 32'(acc_addr));
                    if (acc_we) begin
                        check("wr_oe_n", 32'(flash_oe_n), 1);
                        check("wr_data_t", 32'(flash_data_t), 0);
                        check("wr_data_o", 32'(flash_data_o), 32'(acc_wdata));
                        check("wr_we_n", 32'(flash_we_n), (k >= S + 1 && k <= S + P) ? 0 : 1);
                    end else begin
                        check("rd_oe_n", 32'(flash_oe_n), 0);
                        check("rd_data_t", 32'(flash_data_t), 32'hFFFF);
                        check("rd_we_n", 32'(flash_we_n), 1);
                    end
                end else begin
                    strobes_idle("done");
                end
            end else begin
                strobes_idle("idle");
                check("busy_idle", 32'(busy), 0);
            end
        end

        rsp_chk(0, rsp0_valid, rsp0_rdata);
        rsp_chk(1, rsp1_valid, rsp1_rdata);

        if (RESET || active) begin
            check("rdy0_off", 32'(req0_ready), 0);
            check("rdy1_off", 32'(req1_ready), 0);
        end else begin
            er0 = req0_valid && (!req1_valid || last_port);
            er1 = req1_valid && !er0;
            check("rdy0", 32'(req0_ready), 32'(er0));
            check("rdy1", 32'(req1_ready), 32'(er1));
        end

        if (!RESET && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
            last_port = (req1_valid && req1_ready);
            acc_cyc   = cyc;
            acc_we    = last_port ? req1_we : req0_we;
            acc_addr  = last_port ? req1_addr : req0_addr;
            acc_wdata = last_port ? req1_wdata : req0_wdata;
            active    = 1'b1;
            e.rdata   = acc_we ? 16'h0000 : pat(acc_addr);
            e.due     = cyc + (acc_we ? (S + P + H + 1) : (RD + 1));
            if (last_port) q1.push_back(e);
            else q0.push_back(e);
            acc_log.push_back('{port: int'(last_port), cyc: cyc});
        end
    end

    task automatic do_req(input int port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int c0);
        @(posedge CLK); #1;
        if (port == 0) begin
            req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end
        c0 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ((port == 0) ? req0_ready : req1_ready) begin
                c0 = cyc;
                break;
            end
        end
        if (c0 < 0) check("req_timeout", 1, 0);
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!busy && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int t0;
        logic got;

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (2) @(posedge CLK);

        // single read, port 0
        do_req(0, 1'b0, 26'h0000123, 16'h0000, c0);
        wait_idle();

        // single write, port 1, top address
        do_req(1, 1'b1, 26'h3FFFFFF, 16'h1234, c0);
        wait_idle();

        // both ports streaming reads
        acc_log.delete();
        @(posedge CLK); #1;
        req0_we = 1'b0; req0_addr = 26'h00ABCDE; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = 26'h2000001; req1_valid = 1'b1;
        repeat (50) @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_count", 32'(acc_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            check("rr_port", 32'(acc_log[i].port), 32'(i % 2));
            if (i > 0) check("rr_spacing", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 12);
        end
        wait_idle();

        // reset in cycle 4 of a port-0 write; pointer would otherwise favour port 1
        do_req(0, 1'b1, 26'h0000155, 16'hBEEF, c0);
        while (cyc < c0 + 4) begin
            @(posedge CLK); #1;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        acc_log.delete();
        req0_we = 1'b0; req0_addr = 26'h0000777; req0_valid = 1'b1;
        req1_we = 1'b0; req1_addr = 26'h1000888; req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (acc_log.size() > 0) begin got = 1'b1; break; end
        end
        check("post_rst_accept", 32'(got), 1);
        if (got) check("post_rst_port", 32'(acc_log[0].port), 0);
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // fast instance: RD_WAIT=1, TURN=0
        @(posedge CLK); #1;
        f_req0_we = 1'b0; f_req0_addr = 26'h0000042; f_req0_valid = 1'b1;
        t0 = cyc;
        @(negedge CLK);
        check("f_acc0", 32'(f_req0_ready), 1);
        @(posedge CLK); #1;
        f_req0_addr = 26'h1000077;
        @(negedge CLK);
        check("f_c1_ce_n", 32'(f_ce_n), 0);
        check("f_c1_oe_n", 32'(f_oe_n), 0);
        check("f_c1_addr", 32'(f_addr_num), 32'h0000042);
        check("f_c1_ready", 32'(f_req0_ready), 0);
        check("f_c1_rsp", 32'(f_rsp0_valid), 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("f_c2_rsp", 32'(f_rsp0_valid), 1);
        check("f_c2_rdata", 32'(f_rsp0_rdata), 32'(pat(26'h0000042)));
        check("f_c2_ce_n", 32'(f_ce_n), 1);
        check("f_c2_ready", 32'(f_req0_ready), 0);
        check("f_c2_rsp1", 32'(f_rsp1_valid), 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("f_c3_ready", 32'(f_req0_ready), 1);
        check("f_c3_rsp", 32'(f_rsp0_valid), 0);
        check("f_c3_cycle", 32'(cyc - t0), 3);
        @(posedge CLK); #1;
        f_req0_valid = 1'b0;
        @(negedge CLK);
        check("f_c4_ce_n", 32'(f_ce_n), 0);
        check("f_c4_addr", 32'(f_addr_num), 32'h1000077);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("f_c5_rsp", 32'(f_rsp0_valid), 1);
        check("f_c5_rdata", 32'(f_rsp0_rdata), 32'(pat(26'h1000077)));
        @(posedge CLK); #1;
        @(negedge CLK);
        check("f_idle_busy", 32'(f_busy), 0);
        check("f_idle_rsp", 32'(f_rsp0_valid), 0);

        repeat (3) @(posedge CLK);
        check("sb_empty", 32'(q0.size() + q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
